// File: rtl/jtdsp16_prog_loader_pkg.sv
// Shared definitions for the jtdsp16 program loader.
//   DSP16_PROG_AW  : default program address width, shared with the jtdsp16 core
//   loader_state_t : loader FSM states
//   pack_word()    : joins the two bytes of a pair into a program word
package jtdsp16_prog_loader_pkg;

    localparam int DSP16_PROG_AW = 12;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_HOLD  = 3'd3,
        ST_RUN   = 3'd4
    } loader_state_t;

    // first_byte is the byte that arrived first in the download stream.
    function automatic logic [15:0] pack_word(input logic [7:0] first_byte,
                                              input logic [7:0] second_byte,
                                              input logic       big_endian);
        return big_endian ? {first_byte, second_byte} : {second_byte, first_byte};
    endfunction

endpackage

// File: rtl/jtdsp16_prog_loader_if.sv
// Download-stream and program-ROM write bus seen by the loader.
//   dwn_en/dwn_wr/dwn_byte    : byte download stream (host -> loader)
//   prog_addr/prog_data/prog_we: program ROM write port (loader -> jtdsp16)
// Modports: master = download host side, slave = loader side.
interface jtdsp16_prog_loader_if
    import jtdsp16_prog_loader_pkg::*;
#(
    parameter int AW = DSP16_PROG_AW
);
    logic          dwn_en;
    logic          dwn_wr;
    logic [7:0]    dwn_byte;
    logic [AW-1:0] prog_addr;
    logic [15:0]   prog_data;
    logic          prog_we;

    modport master (
        output dwn_en, dwn_wr, dwn_byte,
        input  prog_addr, prog_data, prog_we
    );

    modport slave (
        input  dwn_en, dwn_wr, dwn_byte,
        output prog_addr, prog_data, prog_we
    );
endinterface

// File: rtl/jtdsp16_byte_pack.sv
// Byte pairing for the program loader.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : drop any pending byte (start of a new load)
//   wr        : accepted download byte strobe, data on data_byte
//   flush     : end of stream; a pending byte is emitted padded with 0x00
//   word      : assembled word, valid in the same cycle as word_vld
//   word_vld  : one-cycle pulse when a pair (or a flushed single byte) completes
module jtdsp16_byte_pack
    import jtdsp16_prog_loader_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        wr,
    input  logic [7:0]  data_byte,
    input  logic        flush,
    output logic [15:0] word,
    output logic        word_vld
);

    logic       pend_q,  pend_d;
    logic [7:0] first_q, first_d;

    always_comb begin
        // word/word_vld are combinational so the top can register prog_we
        // exactly one cycle after the completing byte.
        word_vld = pend_q & (wr | flush) & ~clr;
        word     = pack_word(first_q, wr ? data_byte : 8'h00, BIG_ENDIAN);
        pend_d   = pend_q;
        first_d  = first_q;
        if (clr || word_vld) begin
            pend_d = 1'b0;
        end else if (wr) begin
            pend_d  = 1'b1;
            first_d = data_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q  <= 1'b0;
            first_q <= 8'h00;
        end else begin
            pend_q  <= pend_d;
            first_q <= first_d;
        end
    end

endmodule

// File: rtl/jtdsp16_prog_loader.sv
// Program loader for the jtdsp16 program ROM.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of the download stream / program write bus
//   dsp_rst  : reset to the DSP; low only in RUN
//   done     : high in RUN
//   ovf      : sticky, a word arrived after the ROM was already full
//   word_cnt : words written by the current or last load (max 2**AW)
//   sum      : mod-2^16 sum of written words
// Flow: IDLE -> LOAD -> FLUSH -> HOLD -> RUN; dwn_en in HOLD/RUN restarts LOAD.
module jtdsp16_prog_loader
    import jtdsp16_prog_loader_pkg::*;
#(
    parameter int AW         = DSP16_PROG_AW,
    parameter bit BIG_ENDIAN = 1'b1,
    parameter int RST_HOLD   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    jtdsp16_prog_loader_if.slave  bus,
    output logic                  dsp_rst,
    output logic                  done,
    output logic                  ovf,
    output logic [AW:0]           word_cnt,
    output logic [15:0]           sum
);

    localparam logic [AW:0]   FULL_CNT  = {1'b1, {AW{1'b0}}};
    localparam logic [AW-1:0] ADDR_MAX  = {AW{1'b1}};
    localparam logic [7:0]    HOLD_INIT = 8'(RST_HOLD - 1);

    loader_state_t state_q, state_d;
    logic [7:0]    hold_cnt_q, hold_cnt_d;
    logic [AW-1:0] prog_addr_q, prog_addr_d;
    logic [15:0]   prog_data_q, prog_data_d;
    logic          prog_we_q, prog_we_d;
    logic [AW:0]   word_cnt_q, word_cnt_d;
    logic [15:0]   sum_q, sum_d;
    logic          ovf_q, ovf_d;
    logic          dsp_rst_q, dsp_rst_d;
    logic          done_q, done_d;

    logic          start_load;
    logic          pack_wr;
    logic          pack_flush;
    logic [15:0]   pk_word;
    logic          pk_vld;

    jtdsp16_byte_pack #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_pack (
        .clk       (clk),
        .rst       (rst),
        .clr       (start_load),
        .wr        (pack_wr),
        .data_byte (bus.dwn_byte),
        .flush     (pack_flush),
        .word      (pk_word),
        .word_vld  (pk_vld)
    );

    // Sequencing: kept apart from the datapath block because the datapath
    // consumes pk_vld, which is itself a function of pack_wr/pack_flush.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        start_load = 1'b0;
        pack_wr    = 1'b0;
        pack_flush = 1'b0;
        case (state_q)
            ST_IDLE: start_load = bus.dwn_en;
            ST_LOAD: begin
                if (bus.dwn_en) begin
                    pack_wr = bus.dwn_wr;
                end else begin
                    // A pending byte leaves as a word now; its prog_we falls in
                    // the single FLUSH cycle and its commit ends FLUSH.
                    pack_flush = 1'b1;
                    state_d    = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_d    = ST_HOLD;
                hold_cnt_d = HOLD_INIT;
            end
            ST_HOLD: begin
                if (bus.dwn_en) begin
                    start_load = 1'b1;
                end else if (hold_cnt_q == 8'd0) begin
                    state_d = ST_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q - 8'd1;
                end
            end
            ST_RUN:  start_load = bus.dwn_en;
            default: state_d = ST_IDLE;
        endcase
        if (start_load) begin
            state_d = ST_LOAD;
        end
    end

    // Datapath: write issue, commit of last cycle's write, counters, status.
    always_comb begin
        prog_addr_d = prog_addr_q;
        prog_data_d = prog_data_q;
        prog_we_d   = 1'b0;
        word_cnt_d  = word_cnt_q;
        sum_d       = sum_q;
        ovf_d       = ovf_q;

        // Commit the write presented during this cycle. The address stops at
        // the last location; a full ROM is reported through ovf instead.
        if (prog_we_q) begin
            word_cnt_d = word_cnt_q + 1'b1;
            sum_d      = sum_q + prog_data_q;
            if (prog_addr_q != ADDR_MAX) begin
                prog_addr_d = prog_addr_q + 1'b1;
            end
        end

        // Words complete at most every other cycle, so word_cnt_q is already
        // up to date whenever pk_vld is seen.
        if (pk_vld) begin
            if (word_cnt_q == FULL_CNT) begin
                ovf_d = 1'b1;
            end else begin
                prog_we_d   = 1'b1;
                prog_data_d = pk_word;
            end
        end

        if (start_load) begin
            prog_addr_d = '0;
            word_cnt_d  = '0;
            sum_d       = 16'h0000;
            ovf_d       = 1'b0;
        end

        dsp_rst_d = (state_d != ST_RUN);
        done_d    = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hold_cnt_q  <= 8'd0;
            prog_addr_q <= '0;
            prog_data_q <= 16'h0000;
            prog_we_q   <= 1'b0;
            word_cnt_q  <= '0;
            sum_q       <= 16'h0000;
            ovf_q       <= 1'b0;
            dsp_rst_q   <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            prog_addr_q <= prog_addr_d;
            prog_data_q <= prog_data_d;
            prog_we_q   <= prog_we_d;
            word_cnt_q  <= word_cnt_d;
            sum_q       <= sum_d;
            ovf_q       <= ovf_d;
            dsp_rst_q   <= dsp_rst_d;
            done_q      <= done_d;
        end
    end

    assign bus.prog_addr = prog_addr_q;
    assign bus.prog_data = prog_data_q;
    assign bus.prog_we   = prog_we_q;
    assign dsp_rst       = dsp_rst_q;
    assign done          = done_q;
    assign ovf           = ovf_q;
    assign word_cnt      = word_cnt_q;
    assign sum           = sum_q;

endmodule

// File: tb/tb_jtdsp16_prog_loader.sv
// Bench for jtdsp16_prog_loader. One download stream drives three loaders:
//   dut 0: AW=12, big endian   dut 1: AW=12, little endian   dut 2: AW=4, big endian
// Expected writes, counts, checksum and overflow come from the byte list of
// each load, paired and truncated to the ROM size with plain arithmetic.
module tb_jtdsp16_prog_loader;

    localparam int HOLD = 16;

    logic       clk;
    logic       rst;
    logic       dwn_en;
    logic       dwn_wr;
    logic [7:0] dwn_byte;

    int total = 0;
    int bad   = 0;

    jtdsp16_prog_loader_if #(.AW(12)) if_a ();
    jtdsp16_prog_loader_if #(.AW(12)) if_b ();
    jtdsp16_prog_loader_if #(.AW(4))  if_c ();

    assign if_a.dwn_en = dwn_en; assign if_a.dwn_wr = dwn_wr; assign if_a.dwn_byte = dwn_byte;
    assign if_b.dwn_en = dwn_en; assign if_b.dwn_wr = dwn_wr; assign if_b.dwn_byte = dwn_byte;
    assign if_c.dwn_en = dwn_en; assign if_c.dwn_wr = dwn_wr; assign if_c.dwn_byte = dwn_byte;

    logic        rst_a, rst_b, rst_c, done_a, done_b, done_c, ovf_a, ovf_b, ovf_c;
    logic [12:0] cnt_a, cnt_b;
    logic [4:0]  cnt_c;
    logic [15:0] sum_a, sum_b, sum_c;

    jtdsp16_prog_loader #(.AW(12), .BIG_ENDIAN(1'b1), .RST_HOLD(HOLD)) dut_a (
        .clk(clk), .rst(rst), .bus(if_a.slave), .dsp_rst(rst_a), .done(done_a),
        .ovf(ovf_a), .word_cnt(cnt_a), .sum(sum_a));
    jtdsp16_prog_loader #(.AW(12), .BIG_ENDIAN(1'b0), .RST_HOLD(HOLD)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b.slave), .dsp_rst(rst_b), .done(done_b),
        .ovf(ovf_b), .word_cnt(cnt_b), .sum(sum_b));
    jtdsp16_prog_loader #(.AW(4), .BIG_ENDIAN(1'b1), .RST_HOLD(HOLD)) dut_c (
        .clk(clk), .rst(rst), .bus(if_c.slave), .dsp_rst(rst_c), .done(done_c),
        .ovf(ovf_c), .word_cnt(cnt_c), .sum(sum_c));

    // Uniform per-dut views.
    logic        st_rst [3];
    logic        st_done[3];
    logic        st_ovf [3];
    logic [12:0] st_cnt [3];
    logic [15:0] st_sum [3];
    logic        st_we  [3];
    logic [11:0] st_addr[3];
    logic [15:0] st_data[3];

    assign st_rst[0]  = rst_a;  assign st_rst[1]  = rst_b;  assign st_rst[2]  = rst_c;
    assign st_done[0] = done_a; assign st_done[1] = done_b; assign st_done[2] = done_c;
    assign st_ovf[0]  = ovf_a;  assign st_ovf[1]  = ovf_b;  assign st_ovf[2]  = ovf_c;
    assign st_cnt[0]  = cnt_a;  assign st_cnt[1]  = cnt_b;  assign st_cnt[2]  = {8'd0, cnt_c};
    assign st_sum[0]  = sum_a;  assign st_sum[1]  = sum_b;  assign st_sum[2]  = sum_c;
    assign st_we[0]   = if_a.prog_we;   assign st_we[1]   = if_b.prog_we;
    assign st_we[2]   = if_c.prog_we;
    assign st_addr[0] = if_a.prog_addr; assign st_addr[1] = if_b.prog_addr;
    assign st_addr[2] = {8'd0, if_c.prog_addr};
    assign st_data[0] = if_a.prog_data; assign st_data[1] = if_b.prog_data;
    assign st_data[2] = if_c.prog_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every ROM write seen on each dut, {addr, data}.
    logic [27:0] obs0[$];
    logic [27:0] obs1[$];
    logic [27:0] obs2[$];

    always @(posedge clk) begin
        if (st_we[0] === 1'b1) obs0.push_back({st_addr[0], st_data[0]});
        if (st_we[1] === 1'b1) obs1.push_back({st_addr[1], st_data[1]});
        if (st_we[2] === 1'b1) obs2.push_back({st_addr[2], st_data[2]});
    end

    logic [7:0] cur_bytes[$];

    task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
        total++;
        if (obs_v !== exp_v) begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs_v, exp_v);
        end
    endtask

    function automatic int daw(input int d);
        return (d == 2) ? 4 : 12;
    endfunction

    function automatic bit dbe(input int d);
        return (d != 1);
    endfunction

    task automatic check_reset();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_dsp_rst[%0d]", d), st_rst[d], 1'b1);
            chk($sformatf("rst_done[%0d]", d), st_done[d], 1'b0);
            chk($sformatf("rst_ovf[%0d]", d), st_ovf[d], 1'b0);
            chk($sformatf("rst_cnt[%0d]", d), st_cnt[d], 13'd0);
            chk($sformatf("rst_sum[%0d]", d), st_sum[d], 16'h0000);
            chk($sformatf("rst_we[%0d]", d), st_we[d], 1'b0);
            chk($sformatf("rst_addr[%0d]", d), st_addr[d], 12'h000);
            chk($sformatf("rst_data[%0d]", d), st_data[d], 16'h0000);
        end
    endtask

    // Compare every dut against the byte list of the load just finished.
    task automatic check_load(input bit in_run);
        logic [27:0] obs[$];
        for (int d = 0; d < 3; d++) begin
            int          cap;
            int          nw;
            int          nexp;
            logic [15:0] s;
            logic [15:0] w;
            logic [7:0]  b0;
            logic [7:0]  b1;
            if (d == 0)      obs = obs0;
            else if (d == 1) obs = obs1;
            else             obs = obs2;
            cap  = 1 << daw(d);
            nw   = (cur_bytes.size() + 1) / 2;
            nexp = (nw < cap) ? nw : cap;
            chk($sformatf("n_writes[%0d]", d), obs.size(), nexp);
            s = 16'h0000;
            for (int i = 0; i < nexp; i++) begin
                b0 = cur_bytes[2*i];
                b1 = (2*i + 1 < cur_bytes.size()) ? cur_bytes[2*i+1] : 8'h00;
                w  = dbe(d) ? {b0, b1} : {b1, b0};
                s  = s + w;
                if (i < obs.size())
                    chk($sformatf("write%0d[%0d]", i, d), obs[i], {12'(i), w});
            end
            chk($sformatf("word_cnt[%0d]", d), st_cnt[d], 13'(nexp));
            chk($sformatf("sum[%0d]", d), st_sum[d], s);
            chk($sformatf("ovf[%0d]", d), st_ovf[d], (nw > cap) ? 1'b1 : 1'b0);
            chk($sformatf("done[%0d]", d), st_done[d], in_run);
            chk($sformatf("dsp_rst[%0d]", d), st_rst[d], !in_run);
        end
    endtask

    // Download cur_bytes with random gaps. from_run: the loaders are in
    // RUN/HOLD, so the restart clear is checked. abort: stop while in HOLD.
    task automatic do_load(input bit from_run, input bit abort);
        int k;
        obs0.delete(); obs1.delete(); obs2.delete();
        dwn_en = 1'b1;
        @(negedge clk);
        if (from_run) begin
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("restart_dsp_rst[%0d]", d), st_rst[d], 1'b1);
                chk($sformatf("restart_done[%0d]", d), st_done[d], 1'b0);
                chk($sformatf("restart_cnt[%0d]", d), st_cnt[d], 13'd0);
                chk($sformatf("restart_sum[%0d]", d), st_sum[d], 16'h0000);
                chk($sformatf("restart_ovf[%0d]", d), st_ovf[d], 1'b0);
            end
        end
        foreach (cur_bytes[i]) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            dwn_wr   = 1'b1;
            dwn_byte = cur_bytes[i];
            @(negedge clk);
            dwn_wr   = 1'b0;
            dwn_byte = 8'($urandom);
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        dwn_en = 1'b0;
        @(negedge clk);
        if (abort) begin
            repeat (3) @(negedge clk);
            check_load(1'b0);
        end else begin
            // The FLUSH cycle plus HOLD cycles with dsp_rst still high.
            k = 0;
            while (st_rst[0] !== 1'b0 && k < 200) begin
                @(negedge clk);
                k++;
            end
            chk("rst_release_cycles", k, 1 + HOLD);
            check_load(1'b1);
        end
        $display("load: bytes=%0d abort=%0d cnt=%0d/%0d/%0d sum=%04h/%04h/%04h ovf=%0d/%0d/%0d",
                 cur_bytes.size(), abort, st_cnt[0], st_cnt[1], st_cnt[2],
                 st_sum[0], st_sum[1], st_sum[2], st_ovf[0], st_ovf[1], st_ovf[2]);
    endtask

    task automatic random_bytes(input int n);
        cur_bytes.delete();
        for (int i = 0; i < n; i++) cur_bytes.push_back(8'($urandom));
    endtask

    initial begin
        rst      = 1'b1;
        dwn_en   = 1'b0;
        dwn_wr   = 1'b0;
        dwn_byte = 8'h00;
        repeat (3) @(negedge clk);
        check_reset();
        rst = 1'b0;
        @(negedge clk);

        // Even load, both byte orders.
        cur_bytes = '{8'h12, 8'h34, 8'h56, 8'h78};
        do_load(1'b0, 1'b0);
        chk("t1_sum_be", st_sum[0], 16'h68AC);
        chk("t2_sum_le", st_sum[1], 16'hAC68);
        chk("t1_cnt", st_cnt[0], 13'd2);

        // Odd load from RUN: last byte flushed with 0x00 fill.
        cur_bytes = '{8'hAB, 8'hCD, 8'hEF};
        do_load(1'b1, 1'b0);
        chk("t3_sum_be", st_sum[0], 16'h9ACD);
        chk("t3_sum_le", st_sum[1], 16'hCE9A);

        // 17 words: the AW=4 loader fills up and flags overflow.
        random_bytes(34);
        do_load(1'b1, 1'b0);
        chk("t4_cnt_c", st_cnt[2], 13'd16);
        chk("t4_ovf_c", st_ovf[2], 1'b1);

        // Restart while in HOLD.
        random_bytes(6);
        do_load(1'b1, 1'b1);
        random_bytes(5);
        do_load(1'b1, 1'b0);

        // Reset with half a pair pending: the pending byte must be dropped.
        dwn_en = 1'b1;
        @(negedge clk);
        dwn_wr   = 1'b1;
        dwn_byte = 8'h5A;
        @(negedge clk);
        dwn_wr = 1'b0;
        @(negedge clk);
        rst    = 1'b1;
        dwn_en = 1'b0;
        @(negedge clk);
        check_reset();
        rst = 1'b0;
        @(negedge clk);
        cur_bytes = '{8'h00, 8'h01};
        do_load(1'b0, 1'b0);
        chk("t6_sum_be", st_sum[0], 16'h0001);
        chk("t6_sum_le", st_sum[1], 16'h0100);

        // Random lengths, including empty loads and overflow on the flushed word.
        random_bytes(33);
        do_load(1'b1, 1'b0);
        random_bytes(0);
        do_load(1'b1, 1'b0);
        repeat (5) begin
            random_bytes($urandom_range(0, 40));
            do_load(1'b1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
